// File: rtl/img2col_pkg.sv
// img2col_pkg: shared defaults, tag field widths and the fetch FSM state type
// for the img2col fetch path. No ports; imported by img2col_fetch_ctrl.
package img2col_pkg;
    localparam int IMG_W  = 32;
    localparam int K      = 5;
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int ROW_W  = 5;
    localparam int TAP_W  = 3;
    localparam int COL_W  = 6;
    localparam int TAG_W  = ROW_W + TAP_W + COL_W;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/pix_skid_fifo.sv
// pix_skid_fifo: 2-entry fall-through FIFO carrying a pixel and its tags.
// Ports: clk, nrst (async active-low); push_i/push_data_i write side;
// ready_i downstream ready; valid_o/data_o head; count_o stored occupancy.
// When empty, an incoming word is presented on the same cycle, and it is
// written only if it is not consumed immediately.
module pix_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         rd_q, wr_q;
    logic [1:0]   count_q;
    logic         empty, wr, rd;

    assign empty   = count_q == 2'd0;
    assign valid_o = !empty || push_i;
    assign data_o  = !empty ? mem_q[rd_q] : push_i ? push_data_i : '0;
    assign wr      = push_i && !(empty && ready_i);
    assign rd      = valid_o && ready_i && !empty;
    assign count_o = count_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (wr) mem_q[wr_q] <= push_data_i;
            wr_q    <= wr_q ^ wr;
            rd_q    <= rd_q ^ rd;
            count_q <= count_q + {1'b0, wr} - {1'b0, rd};
        end
    end
endmodule

// File: rtl/img2col_fetch_ctrl.sv
// img2col_fetch_ctrl: streams an image from SRAM in img2col order
// (row, kernel tap, column) with tagged pixels on a valid/ready port.
// Ports: clk, nrst (async active-low); start_i/base_addr_i launch a frame;
// busy_o/done_o status; mem_req_o/mem_addr_o/mem_rdata_i SRAM read port
// (1-cycle latency); pix_valid_o/pix_ready_i/pix_data_o/pix_row_o/
// pix_tap_o/pix_col_o pixel stream; row_done_o marks the end of an output row.
module img2col_fetch_ctrl #(
    parameter int IMG_W  = img2col_pkg::IMG_W,
    parameter int K      = img2col_pkg::K,
    parameter int ADDR_W = img2col_pkg::ADDR_W,
    parameter int DATA_W = img2col_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             base_addr_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          mem_req_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic                          pix_valid_o,
    input  logic                          pix_ready_i,
    output logic [DATA_W-1:0]             pix_data_o,
    output logic [img2col_pkg::ROW_W-1:0] pix_row_o,
    output logic [img2col_pkg::TAP_W-1:0] pix_tap_o,
    output logic [img2col_pkg::COL_W-1:0] pix_col_o,
    output logic                          row_done_o
);
    import img2col_pkg::*;
    localparam int OUT_W = IMG_W - K + 1;

    fetch_state_t        state_q, state_d;
    logic [ROW_W-1:0]    row_q;
    logic [TAP_W-1:0]    tap_q;
    logic [COL_W-1:0]    col_q;
    logic [ADDR_W-1:0]   base_q;
    logic                inflight_q;
    logic [TAG_W-1:0]    tag_q;
    logic [1:0]          count;
    logic [DATA_W+TAG_W-1:0] head;
    logic last_col, last_tap, last_row, fire, accept;

    assign last_col   = col_q == COL_W'(IMG_W - 1);
    assign last_tap   = tap_q == TAP_W'(K - 1);
    assign last_row   = row_q == ROW_W'(OUT_W - 1);
    assign accept     = state_q == IDLE && start_i;
    assign fire       = pix_valid_o && pix_ready_i;
    assign mem_addr_o = base_q + (ADDR_W'(row_q) + ADDR_W'(tap_q)) * ADDR_W'(IMG_W) + ADDR_W'(col_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Leaving DRAIN on the final transfer means the FIFO is empty and nothing
    // is in flight from the next cycle on.
    always_comb begin
        state_d = accept ? FETCH :
                  (state_q == FETCH && mem_req_o && last_row && last_tap && last_col) ? DRAIN :
                  (state_q == DRAIN && done_o) ? IDLE : state_q;
    end

    // Credit limit: stored entries plus the outstanding read never exceed 2.
    always_comb begin
        busy_o     = state_q != IDLE;
        mem_req_o  = state_q == FETCH && ({1'b0, count} + {2'b0, inflight_q}) < 3'd2;
        row_done_o = fire && pix_tap_o == TAP_W'(K - 1) && pix_col_o == COL_W'(IMG_W - 1);
        done_o     = state_q == DRAIN && row_done_o && pix_row_o == ROW_W'(OUT_W - 1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_q      <= '0;
            tap_q      <= '0;
            col_q      <= '0;
            base_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= mem_req_o;
            if (mem_req_o) tag_q <= {row_q, tap_q, col_q};
            if (accept) begin
                row_q  <= '0;
                tap_q  <= '0;
                col_q  <= '0;
                base_q <= base_addr_i;
            end else if (mem_req_o) begin
                col_q <= last_col ? '0 : col_q + 1'b1;
                tap_q <= !last_col ? tap_q : last_tap ? '0 : tap_q + 1'b1;
                row_q <= !(last_col && last_tap) ? row_q : last_row ? '0 : row_q + 1'b1;
            end
        end
    end

    pix_skid_fifo #(.W(DATA_W + TAG_W)) u_fifo (
        .clk         (clk),
        .nrst        (nrst),
        .push_i      (inflight_q),
        .push_data_i ({mem_rdata_i, tag_q}),
        .ready_i     (pix_ready_i),
        .valid_o     (pix_valid_o),
        .data_o      (head),
        .count_o     (count)
    );

    assign {pix_data_o, pix_row_o, pix_tap_o, pix_col_o} = head;
endmodule

// File: tb/tb_img2col_fetch_ctrl.sv
// tb_img2col_fetch_ctrl: randomized self-checking bench for img2col_fetch_ctrl
module tb_img2col_fetch_ctrl;
    localparam int IMG_W = 32;
    localparam int K     = 5;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int NPIX  = OUT_W * K * IMG_W;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] base_addr = '0;
    logic       busy, done, mem_req, pix_valid, row_done;
    logic       pix_ready = 1'b0;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata = '0;
    logic [7:0] pix_data;
    logic [4:0] pix_row;
    logic [2:0] pix_tap;
    logic [5:0] pix_col;

    logic [7:0] sram [1024];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$], obs_q[$], eaddr_q[$], oaddr_q[$];
    int done_cnt, rowdone_cnt, first_valid, done_cyc, last_xfer, max_occ, unstable, reqs_stall;
    logic busy_after;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= sram[mem_addr];

    img2col_fetch_ctrl dut (
        .clk         (clk),
        .nrst        (nrst),
        .start_i     (start),
        .base_addr_i (base_addr),
        .busy_o      (busy),
        .done_o      (done),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .pix_valid_o (pix_valid),
        .pix_ready_i (pix_ready),
        .pix_data_o  (pix_data),
        .pix_row_o   (pix_row),
        .pix_tap_o   (pix_tap),
        .pix_col_o   (pix_col),
        .row_done_o  (row_done)
    );

    function automatic int first_diff(input logic [31:0] a[$], input logic [31:0] b[$]);
        int n = a.size() < b.size() ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return a.size() == b.size() ? -1 : n;
    endfunction

    // Reference: the full img2col read order for one frame, straight from the loop nest.
    task automatic build_exp(input logic [9:0] base);
        logic [9:0] a;
        exp_q.delete();
        eaddr_q.delete();
        for (int r = 0; r < OUT_W; r++)
            for (int t = 0; t < K; t++)
                for (int c = 0; c < IMG_W; c++) begin
                    a = base + 10'((r + t) * IMG_W + c);
                    eaddr_q.push_back({22'd0, a});
                    exp_q.push_back({10'd0, sram[a], 5'(r), 3'(t), 6'(c)});
                end
    endtask

    // Drives one frame cycle by cycle and records what the DUT did; no judging here.
    task automatic collect(input bit do_start, input logic [9:0] base, input int ready_pct,
                           input int restart_at, input int stall_len, input int stop_at,
                           input int max_cycles);
        int issued = 0, xfers = 0, end_at = -1;
        logic stalled = 1'b0;
        logic [31:0] held = '0;
        obs_q.delete();
        oaddr_q.delete();
        done_cnt = 0; rowdone_cnt = 0; first_valid = -1; done_cyc = -1; last_xfer = -1;
        max_occ = 0; unstable = 0; reqs_stall = -1; busy_after = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            start = (do_start && c == 0) || c == restart_at;
            base_addr = c == 0 ? base : 10'($urandom);
            if (stall_len > 0 && (first_valid < 0 || c < first_valid + stall_len)) pix_ready = 1'b0;
            else pix_ready = $urandom_range(99) < ready_pct;
            #1;
            if (stalled && (!pix_valid || {10'd0, pix_data, pix_row, pix_tap, pix_col} !== held)) unstable++;
            if (issued - xfers > max_occ) max_occ = issued - xfers;
            if (pix_valid && first_valid < 0) first_valid = c;
            if (mem_req) begin
                oaddr_q.push_back({22'd0, mem_addr});
                issued++;
            end
            if (pix_valid && pix_ready) begin
                obs_q.push_back({10'd0, pix_data, pix_row, pix_tap, pix_col});
                xfers++;
                last_xfer = c;
            end
            if (row_done) rowdone_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            stalled = pix_valid && !pix_ready;
            held = {10'd0, pix_data, pix_row, pix_tap, pix_col};
            if (stall_len > 0 && first_valid >= 0 && c == first_valid + stall_len - 1) reqs_stall = issued;
            if (c == end_at) begin
                busy_after = busy;
                break;
            end
            if (done && end_at < 0) end_at = c + 1;
            if (c == stop_at) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, done, mem_req, pix_valid, row_done, mem_addr, pix_data, pix_row, pix_tap, pix_col} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b done=%b req=%b valid=%b rowdone=%b addr=%h data=%h tags=%0d/%0d/%0d, all required 0",
                     busy, done, mem_req, pix_valid, row_done, mem_addr, pix_data, pix_row, pix_tap, pix_col);
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, mem_req, pix_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b req=%b valid=%b, required 000", busy, mem_req, pix_valid);
        end
    endtask

    task automatic test_full_frame;
        int d;
        build_exp(10'd0);
        collect(1'b1, 10'd0, 100, -1, 0, -1, 6000);
        d = first_diff(obs_q, exp_q);
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL full_stream: first diff at %0d got %h required %h (count %0d of %0d)", d, obs_q[d], exp_q[d], obs_q.size(), NPIX);
        end
        d = first_diff(oaddr_q, eaddr_q);
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL full_addrs: first diff at %0d got %h required %h", d, oaddr_q[d], eaddr_q[d]);
        end
        n_cmp++;
        if (oaddr_q.size() < 33 || oaddr_q[0] !== 32'd0 || oaddr_q[32] !== 32'd32) begin
            n_bad++;
            $display("FAIL full_addr_0_32: got %h,%h required 0,20", oaddr_q[0], oaddr_q[32]);
        end
        n_cmp++;
        if (rowdone_cnt !== OUT_W) begin
            n_bad++;
            $display("FAIL full_row_done: got %0d required %0d", rowdone_cnt, OUT_W);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_bad++;
            $display("FAIL full_done_count: got %0d required 1", done_cnt);
        end
        n_cmp++;
        if (first_valid !== 2) begin
            n_bad++;
            $display("FAIL full_latency: got %0d required 2", first_valid);
        end
        n_cmp++;
        if (done_cyc !== NPIX + 1 || done_cyc !== last_xfer) begin
            n_bad++;
            $display("FAIL full_done_cycle: got %0d (last transfer %0d) required %0d", done_cyc, last_xfer, NPIX + 1);
        end
        n_cmp++;
        if (busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL full_busy_after_done: got %b required 0", busy_after);
        end
    endtask

    task automatic test_addr_wrap;
        int d;
        build_exp(10'h3F0);
        collect(1'b1, 10'h3F0, 100, -1, 0, -1, 6000);
        n_cmp++;
        if (oaddr_q.size() < 17 || oaddr_q[1] !== 32'h3F1 || oaddr_q[16] !== 32'h000) begin
            n_bad++;
            $display("FAIL wrap_addrs: got %h,%h required 3f1,000", oaddr_q[1], oaddr_q[16]);
        end
        d = first_diff(obs_q, exp_q);
        n_cmp++;
        if (d != -1 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL wrap_stream: first diff %0d got %h required %h, done count %0d required 1", d, obs_q[d], exp_q[d], done_cnt);
        end
    endtask

    task automatic test_random_ready;
        int d;
        logic [9:0] b;
        b = 10'($urandom);
        build_exp(b);
        collect(1'b1, b, 30, -1, 0, -1, 40000);
        d = first_diff(obs_q, exp_q);
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL random_stream: first diff at %0d got %h required %h (count %0d of %0d)", d, obs_q[d], exp_q[d], obs_q.size(), NPIX);
        end
        d = first_diff(oaddr_q, eaddr_q);
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL random_addrs: first diff at %0d got %h required %h", d, oaddr_q[d], eaddr_q[d]);
        end
        n_cmp++;
        if (max_occ > 2 || unstable !== 0) begin
            n_bad++;
            $display("FAIL random_occ_stable: occupancy %0d required <=2, unstable %0d required 0", max_occ, unstable);
        end
        n_cmp++;
        if (done_cnt !== 1 || rowdone_cnt !== OUT_W) begin
            n_bad++;
            $display("FAIL random_done: done %0d required 1, row_done %0d required %0d", done_cnt, rowdone_cnt, OUT_W);
        end
    endtask

    task automatic test_stall;
        int d;
        logic [9:0] b;
        b = 10'($urandom);
        build_exp(b);
        collect(1'b1, b, 100, -1, 10, -1, 6000);
        n_cmp++;
        if (reqs_stall < 0 || reqs_stall > 2) begin
            n_bad++;
            $display("FAIL stall_reqs: got %0d required 0..2", reqs_stall);
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++;
            $display("FAIL stall_stable: got %0d changes required 0", unstable);
        end
        d = first_diff(obs_q, exp_q);
        n_cmp++;
        if (d != -1 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL stall_stream: first diff %0d got %h required %h, done count %0d required 1", d, obs_q[d], exp_q[d], done_cnt);
        end
    endtask

    task automatic test_start_while_busy;
        int d;
        logic [9:0] b;
        b = 10'($urandom);
        build_exp(b);
        collect(1'b1, b, 100, 1000, 0, -1, 6000);
        d = first_diff(obs_q, exp_q);
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL busy_start_stream: first diff at %0d got %h required %h", d, obs_q[d], exp_q[d]);
        end
        n_cmp++;
        if (done_cnt !== 1 || busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_start_done: done %0d required 1, busy after %b required 0", done_cnt, busy_after);
        end
    endtask

    task automatic test_reset_midway;
        int d;
        logic [9:0] b;
        collect(1'b1, 10'($urandom), 60, -1, 0, 300, 400);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, mem_req, pix_valid, row_done, mem_addr, pix_data, pix_row, pix_tap, pix_col} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: busy=%b done=%b req=%b valid=%b rowdone=%b addr=%h data=%h, all required 0",
                     busy, done, mem_req, pix_valid, row_done, mem_addr, pix_data);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, mem_req, pix_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL midreset_idle: busy=%b req=%b valid=%b required 000", busy, mem_req, pix_valid);
        end
        b = 10'($urandom);
        build_exp(b);
        collect(1'b1, b, 100, -1, 0, -1, 6000);
        n_cmp++;
        if (oaddr_q.size() == 0 || oaddr_q[0] !== {22'd0, b}) begin
            n_bad++;
            $display("FAIL midreset_first_addr: got %h required %h", oaddr_q[0], b);
        end
        d = first_diff(obs_q, exp_q);
        n_cmp++;
        if (d != -1 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL midreset_stream: first diff %0d got %h required %h, done count %0d required 1", d, obs_q[d], exp_q[d], done_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 8'($urandom);
        test_reset;
        test_full_frame;
        test_addr_wrap;
        test_random_ready;
        test_stall;
        test_start_while_busy;
        test_reset_midway;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/img2col_fetch_ctrl.md
IMG2COL_FETCH_CTRL -- requirements
Module: img2col_fetch_ctrl

Interface
REQ-001 Parameter IMG_W, 32, input image width/height in pixels.
REQ-002 Parameter K, 5, kernel size; OUT_W = IMG_W-K+1 (28) is derived, not a parameter.
REQ-003 Parameter ADDR_W, 10, image SRAM address width.
REQ-004 Parameter DATA_W, 8, pixel width.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 nrst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a full-image fetch.
REQ-008 base_addr  in  ADDR_W  image base address, sampled on accepted start.
REQ-009 busy  out  1  high from the cycle after accepted start until done.
REQ-010 done  out  1  one-cycle pulse when the last pixel has been accepted downstream.
REQ-011 mem_req  out  1  SRAM read strobe.
REQ-012 mem_addr  out  ADDR_W  SRAM read address.
REQ-013 mem_rdata  in  DATA_W  SRAM data, valid exactly 1 cycle after mem_req.
REQ-014 pix_valid / pix_ready  out / in  1 / 1  downstream valid/ready handshake.
REQ-015 pix_data  out  DATA_W  pixel.
REQ-016 pix_row  out  5  output row index 0..OUT_W-1.
REQ-017 pix_tap  out  3  kernel row index 0..K-1.
REQ-018 pix_col  out  6  image column 0..IMG_W-1.
REQ-019 row_done  out  1  one-cycle pulse when the pixel with pix_tap=K-1, pix_col=IMG_W-1 transfers.

Function
REQ-020 Fetch order: nested loops row 0..OUT_W-1 (outer), tap 0..K-1, col 0..IMG_W-1 (inner); OUT_W*K*IMG_W = 4480 reads per image at defaults.
REQ-021 mem_addr = base_addr + (row+tap)*IMG_W + col, computed in ADDR_W bits, wrapping modulo 2^ADDR_W.
REQ-022 States: IDLE, FETCH, DRAIN; start is accepted only in IDLE and ignored otherwise.
REQ-023 IDLE->FETCH on start; all counters are cleared and base_addr is latched in that cycle.
REQ-024 In FETCH, mem_req is asserted only when (FIFO occupancy + reads in flight) < 2; the counters advance only in cycles where mem_req=1.
REQ-025 FETCH->DRAIN in the cycle that issues the final read (row=OUT_W-1, tap=K-1, col=IMG_W-1).
REQ-026 DRAIN->IDLE when the FIFO is empty and no read is in flight; done pulses in the cycle the last pixel transfers.
REQ-027 Returned data and its row/tap/col tags enter a 2-entry FIFO, and pix_* is driven from the FIFO head; no data loss or duplication occurs under any pix_ready pattern.
REQ-028 pix_valid stays asserted with stable pix_* until pix_ready; a simultaneous FIFO push and pop in the same cycle keeps occupancy unchanged.
REQ-029 With pix_ready held high, throughput is one pixel per cycle after a 2-cycle initial latency (start -> first pix_valid).
REQ-030 No mem_req is issued in IDLE or DRAIN.

Reset
REQ-031 On nrst low: state=IDLE; busy, done, mem_req, pix_valid, and row_done = 0; counters, FIFO, and in-flight flag cleared; mem_addr, pix_data, and tags = 0.
REQ-032 Reset asserted mid-operation aborts immediately; SRAM data returning after reset release is discarded.

Structure
REQ-033 Package img2col_pkg holds IMG_W, K, OUT_W, ADDR_W, DATA_W defaults and the fetch_state_t enum (IDLE, FETCH, DRAIN).
REQ-034 The 2-entry tagged FIFO is a sub-module pix_skid_fifo; the counters, address generation, and FSM reside in img2col_fetch_ctrl.

Verification
REQ-035 base_addr=0, pix_ready=1 -> 4480 pixels, first addr 0, addr 32 after 32 beats, row_done ×28, done exactly once, ~4482 cycles.
REQ-036 base_addr=0x3F0 -> second read addr 0x3F1, addr after 16 reads wraps to 0x000.
REQ-037 pix_ready random 30% -> stream matches reference model order, data never dropped or duplicated, occupancy never >2.
REQ-038 pix_ready=0 for 10 cycles after first valid -> at most 2 mem_req issued, pix_* stable, resumes correctly.
REQ-039 start pulsed while busy -> ignored, single done; nrst pulsed mid-FETCH -> all outputs 0, next start restarts at addr base.
